// File: rtl/csr_event_bank.sv
// GPIO + event/interrupt CSR bank on the J1 i/o bus; the timer channel exists only with CSR_EVT_TIMER_EN.
// Reads are combinational, writes land on the next clk edge; no backpressure, every strobe is accepted.
module csr_event_bank #(
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter int          GPIO_W    = 8,
  parameter int          NUM_EVT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        j1_mem_addr,
  input  logic [15:0]        j1_dout,
  input  logic               j1_io_wr,
  input  logic               j1_io_rd,
  output logic [15:0]        j1_io_din,
  input  logic [GPIO_W-1:0]  gpio_in,
  output logic [GPIO_W-1:0]  gpio_out,
  output logic [GPIO_W-1:0]  gpio_oe,
  input  logic [NUM_EVT-1:0] evt_in,
  output logic               irq
);

  localparam int EW = NUM_EVT + 1;
`ifdef CSR_EVT_TIMER_EN
  localparam logic [EW-1:0] EVT_MASK = {EW{1'b1}};
`else
  localparam logic [EW-1:0] EVT_MASK = {1'b0, {NUM_EVT{1'b1}}};
`endif

  logic [15:0]        off;
  logic               hit;
  logic               wr_hit;
  logic [GPIO_W-1:0]  gpio_s1_q, gpio_s1_d, gpio_s2_q, gpio_s2_d;
  logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d, gpio_oe_q, gpio_oe_d;
  logic [NUM_EVT-1:0] evt_s1_q, evt_s1_d, evt_s2_q, evt_s2_d, evt_prev_q, evt_prev_d;
  logic [EW-1:0]      status_q, status_d, enable_q, enable_d;
  logic [EW-1:0]      raw, evt_set, w1c;
  logic               irq_q, irq_d;
  logic               tmr_set, tmr_zero;
  logic [15:0]        rd_val;
  logic               unused_dout;

  assign off         = j1_mem_addr - BASE_ADDR;
  assign hit         = (off < 16'd8);
  assign wr_hit      = j1_io_wr && hit;
  assign unused_dout = ^j1_dout;

`ifdef CSR_EVT_TIMER_EN
  logic [15:0] tmr_reload_q, tmr_reload_d, tmr_count_q, tmr_count_d;

  // A reload write restarts the count immediately and wins over the free-running update.
  always_comb begin
    tmr_reload_d = tmr_reload_q;
    tmr_count_d  = tmr_count_q;
    tmr_set      = 1'b0;
    if (wr_hit && off[2:0] == 3'd6) begin
      tmr_reload_d = j1_dout;
      tmr_count_d  = j1_dout;
    end else if (tmr_count_q != 16'd0) begin
      tmr_count_d = tmr_count_q - 16'd1;
    end else if (tmr_reload_q != 16'd0) begin
      tmr_count_d = tmr_reload_q;
      tmr_set     = 1'b1;
    end
  end

  assign tmr_zero = (tmr_count_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_reload_q <= '0;
      tmr_count_q  <= '0;
    end else begin
      tmr_reload_q <= tmr_reload_d;
      tmr_count_q  <= tmr_count_d;
    end
  end
`else
  assign tmr_set  = 1'b0;
  assign tmr_zero = 1'b0;
`endif

  always_comb begin
    gpio_s1_d  = gpio_in;
    gpio_s2_d  = gpio_s1_q;
    evt_s1_d   = evt_in;
    evt_s2_d   = evt_s1_q;
    evt_prev_d = evt_s2_q;
    gpio_out_d = gpio_out_q;
    gpio_oe_d  = gpio_oe_q;
    enable_d   = enable_q;
    w1c        = '0;
    if (wr_hit) begin
      case (off[2:0])
        3'd1:    gpio_out_d = j1_dout[GPIO_W-1:0];
        3'd2:    gpio_oe_d  = j1_dout[GPIO_W-1:0];
        3'd3:    w1c        = j1_dout[EW-1:0];
        3'd4:    enable_d   = j1_dout[EW-1:0] & EVT_MASK;
        default: ;
      endcase
    end
    // New events are OR-ed in after the clear so a coincident set survives.
    evt_set  = {tmr_set, evt_s2_q & ~evt_prev_q};
    status_d = (status_q & ~w1c) | evt_set;
    irq_d    = |(status_q & enable_q);
  end

  assign raw = {tmr_zero, evt_s2_q};

  always_comb begin
    rd_val = 16'hBADA;
    if (hit) begin
      case (off[2:0])
        3'd0:    rd_val = 16'(gpio_s2_q);
        3'd1:    rd_val = 16'(gpio_out_q);
        3'd2:    rd_val = 16'(gpio_oe_q);
        3'd3:    rd_val = 16'(status_q);
        3'd4:    rd_val = 16'(enable_q);
        3'd5:    rd_val = 16'(raw);
`ifdef CSR_EVT_TIMER_EN
        3'd6:    rd_val = tmr_reload_q;
        3'd7:    rd_val = tmr_count_q;
`endif
        default: rd_val = 16'hBADA;
      endcase
    end
    j1_io_din = j1_io_rd ? rd_val : 16'hDEAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
      evt_s1_q   <= '0;
      evt_s2_q   <= '0;
      evt_prev_q <= '0;
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      status_q   <= '0;
      enable_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      gpio_s1_q  <= gpio_s1_d;
      gpio_s2_q  <= gpio_s2_d;
      evt_s1_q   <= evt_s1_d;
      evt_s2_q   <= evt_s2_d;
      evt_prev_q <= evt_prev_d;
      gpio_out_q <= gpio_out_d;
      gpio_oe_q  <= gpio_oe_d;
      status_q   <= status_d;
      enable_q   <= enable_d;
      irq_q      <= irq_d;
    end
  end

  assign gpio_out = gpio_out_q;
  assign gpio_oe  = gpio_oe_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_csr_event_bank.sv
// Randomised + directed bench for csr_event_bank; reads are scored against a queue filled at issue time.
module tb_csr_event_bank;
  localparam int BASE = 'h0100;
  localparam int NEVT = 4;
`ifdef CSR_EVT_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif
  localparam int EN_MASK = TMR ? 'h1F : 'h0F;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] j1_mem_addr, j1_dout, j1_io_din;
  logic        j1_io_wr, j1_io_rd;
  logic [7:0]  gpio_in, gpio_out, gpio_oe;
  logic [3:0]  evt_in;
  logic        irq;

  csr_event_bank dut (
    .clk(clk), .rst(rst),
    .j1_mem_addr(j1_mem_addr), .j1_dout(j1_dout),
    .j1_io_wr(j1_io_wr), .j1_io_rd(j1_io_rd), .j1_io_din(j1_io_din),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .evt_in(evt_in), .irq(irq)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  // Reference model: registers as plain integers, synchronisers as sample histories.
  int m_gpio_out = 0, m_gpio_oe = 0, m_status = 0, m_enable = 0;
  int m_reload = 0, m_count = 0, m_irq = 0;
  int evt_smp[$] = '{0, 0, 0};
  int gpio_smp[$] = '{0, 0, 0};
  int m_off, m_w1c, m_rise, m_tset;
  bit m_wr;

  always @(posedge clk) begin
    if (rst) begin
      m_gpio_out = 0; m_gpio_oe = 0; m_status = 0; m_enable = 0;
      m_reload = 0; m_count = 0; m_irq = 0;
      evt_smp = '{0, 0, 0};
      gpio_smp = '{0, 0, 0};
    end else begin
      m_off  = int'(j1_mem_addr) - BASE;
      m_wr   = j1_io_wr && m_off >= 0 && m_off < 8;
      m_irq  = ((m_status & m_enable) != 0) ? 1 : 0;
      m_rise = evt_smp[1] & ~evt_smp[0];
      m_tset = 0;
      if (TMR) begin
        if (m_wr && m_off == 6) begin
          m_reload = int'(j1_dout);
          m_count  = int'(j1_dout);
        end else if (m_count > 0) begin
          m_count = m_count - 1;
        end else if (m_reload > 0) begin
          m_count = m_reload;
          m_tset  = 1;
        end
      end
      m_w1c    = (m_wr && m_off == 3) ? int'(j1_dout) : 0;
      m_status = ((m_status & ~m_w1c) | m_rise | (m_tset << NEVT)) & EN_MASK;
      if (m_wr && m_off == 1) m_gpio_out = int'(j1_dout) & 'hFF;
      if (m_wr && m_off == 2) m_gpio_oe  = int'(j1_dout) & 'hFF;
      if (m_wr && m_off == 4) m_enable   = int'(j1_dout) & EN_MASK;
      evt_smp.push_back(int'(evt_in));
      void'(evt_smp.pop_front());
      gpio_smp.push_back(int'(gpio_in));
      void'(gpio_smp.pop_front());
    end
  end

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    int o;
    o = int'(a) - BASE;
    case (o)
      0: return 16'(gpio_smp[1]);
      1: return 16'(m_gpio_out);
      2: return 16'(m_gpio_oe);
      3: return 16'(m_status);
      4: return 16'(m_enable);
      5: return 16'(evt_smp[1] | ((TMR && m_count == 0) ? (1 << NEVT) : 0));
      6: return TMR ? 16'(m_reload) : 16'hBADA;
      7: return TMR ? 16'(m_count) : 16'hBADA;
      default: return 16'hBADA;
    endcase
  endfunction

  function automatic logic [15:0] ra(input int o);
    return 16'(BASE + o);
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (j1_io_rd) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL read_unexpected: got %h want <no pending read>", j1_io_din);
        end else begin
          exp_v = exp_q.pop_front();
          check($sformatf("read@%h", j1_mem_addr), j1_io_din, exp_v);
        end
      end else begin
        check("idle_din", j1_io_din, 16'hDEAD);
      end
      check("irq", {15'b0, irq}, 16'(m_irq));
      check("gpio_out", {8'b0, gpio_out}, 16'(m_gpio_out));
      check("gpio_oe", {8'b0, gpio_oe}, 16'(m_gpio_oe));
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    j1_io_wr    = w;
    j1_io_rd    = r;
    j1_mem_addr = a;
    j1_dout     = d;
    if (r) exp_q.push_back(exp_rd(a));
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1;
    rst = 1'b1; j1_io_wr = 1'b0; j1_io_rd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int          r_op, r_off;
  logic [15:0] r_addr, r_dat;

  initial begin
    rst = 1'b1; j1_mem_addr = '0; j1_dout = '0; j1_io_wr = 1'b0; j1_io_rd = 1'b0;
    gpio_in = '0; evt_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int o = 0; o < 10; o++) cyc(1'b0, 1'b1, ra(o), 16'h0);

    // GPIO path, undecoded address, idle bus
    cyc(1'b1, 1'b0, ra(1), 16'h00A5);
    cyc(1'b0, 1'b1, ra(1), 16'h0);
    cyc(1'b0, 1'b1, ra(9), 16'h0);
    cyc(1'b1, 1'b0, ra(2), 16'h5A3C);
    gpio_in = 8'h96;
    cyc(1'b1, 1'b0, ra(0), 16'hFFFF);
    repeat (3) cyc(1'b0, 1'b1, ra(0), 16'h0);
    cyc(1'b0, 1'b1, ra(2), 16'h0);

    // event edge -> status -> irq
    cyc(1'b1, 1'b0, ra(4), 16'h0004);
    evt_in = 4'b0100;
    repeat (5) cyc(1'b0, 1'b1, ra(3), 16'h0);
    cyc(1'b1, 1'b0, ra(3), 16'h0004);
    cyc(1'b0, 1'b1, ra(3), 16'h0);
    evt_in = 4'b0000;
    repeat (3) cyc(1'b0, 1'b1, ra(5), 16'h0);
    evt_in = 4'b0100;
    cyc(1'b0, 1'b0, 16'h0, 16'h0);
    cyc(1'b1, 1'b0, ra(3), 16'h0004);
    cyc(1'b0, 1'b1, ra(3), 16'h0);
    cyc(1'b1, 1'b0, ra(3), 16'h0004);
    repeat (3) cyc(1'b0, 1'b1, ra(3), 16'h0);

    // timer period and stop
    cyc(1'b1, 1'b0, ra(4), 16'h0010);
    cyc(1'b1, 1'b0, ra(6), 16'h0003);
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 2) cyc(1'b1, 1'b0, ra(3), 16'h0010);
      else cyc(1'b0, 1'b1, ra((i % 2 == 0) ? 3 : 7), 16'h0);
    end
    cyc(1'b1, 1'b0, ra(6), 16'h0000);
    cyc(1'b1, 1'b0, ra(3), 16'h001F);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, ra(3 + (i % 5)), 16'h0);

    // enable mask width and offset 6 decode
    cyc(1'b1, 1'b0, ra(4), 16'hFFFF);
    cyc(1'b0, 1'b1, ra(4), 16'h0);
    cyc(1'b0, 1'b1, ra(6), 16'h0);

    // reset with everything busy
    cyc(1'b1, 1'b0, ra(1), 16'h00A5);
    cyc(1'b1, 1'b0, ra(6), 16'h0005);
    evt_in = 4'b1011;
    repeat (4) cyc(1'b0, 1'b1, ra(3), 16'h0);
    pulse_rst();
    for (int o = 0; o < 8; o++) cyc(1'b0, 1'b1, ra(o), 16'h0);

    for (int i = 0; i < 500; i++) begin
      r_op  = $urandom_range(0, 9);
      r_off = $urandom_range(0, 9);
      r_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : ra(r_off);
      r_dat  = (r_off == 6) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      if (i == 250) pulse_rst();
      else if (r_op < 4) cyc(1'b0, 1'b1, r_addr, 16'h0);
      else if (r_op < 7) cyc(1'b1, 1'b0, r_addr, r_dat);
      else cyc(1'b0, 1'b0, r_addr, r_dat);
      if ($urandom_range(0, 3) == 0) evt_in = 4'($urandom_range(0, 15));
      gpio_in = 8'($urandom);
    end

    repeat (4) cyc(1'b0, 1'b0, 16'h0, 16'h0);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_event_bank.md
CSR_EVENT_BANK -- requirements
Module: csr_event_bank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0100, word address of register offset 0.
REQ-002 SHALL have parameter GPIO_W, default 8, GPIO width, legal 1..16.
REQ-003 SHALL have parameter NUM_EVT, default 4, external event channels, legal 1..15.
REQ-004 SHALL have port clk  in  1  single clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous to clk and active-high.
REQ-006 SHALL have ports j1_mem_addr in 16 (address), j1_dout in 16 (write data), j1_io_wr in 1 (i/o write strobe), j1_io_rd in 1 (i/o read strobe).
REQ-007 SHALL have port j1_io_din  out  16  read data.
REQ-008 SHALL have ports gpio_in in GPIO_W, gpio_out out GPIO_W, gpio_oe out GPIO_W.
REQ-009 SHALL have ports evt_in in NUM_EVT (asynchronous event sources) and irq out 1 (interrupt request).

Function
REQ-010 SHALL decode registers at BASE_ADDR+off: 0 GPIO_IN RO, 1 GPIO_OUT RW, 2 GPIO_OE RW, 3 EVT_STATUS RO/W1C, 4 EVT_ENABLE RW, 5 EVT_RAW RO, 6 TMR_RELOAD RW, 7 TMR_COUNT RO.
REQ-011 SHALL drive j1_io_din combinationally: zero-extended register value when j1_io_rd and address decoded; 16'hBADA when j1_io_rd and address not decoded; 16'hDEAD when j1_io_rd low.
REQ-012 SHALL take writes only on j1_io_wr, updating the target register at the next clk edge; writes to RO or undecoded addresses SHALL be ignored; upper unused data bits SHALL be ignored.
REQ-013 SHALL synchronise gpio_in and evt_in through two flops; GPIO_IN and EVT_RAW read the second stage.
REQ-014 SHALL set EVT_STATUS[i] on a rising edge of synchronised evt_in[i]: input high sampled at edge k -> status reads 1 after edge k+2.
REQ-015 SHALL clear EVT_STATUS bits written 1 at offset 3; bits written 0 unchanged.
REQ-016 SHALL, when set and W1C hit the same bit in the same cycle, leave the bit set.
REQ-017 SHALL register irq = OR(EVT_STATUS & EVT_ENABLE), one cycle after status/enable change.
REQ-018 SHALL, for timer (bit NUM_EVT of status/enable/raw), load TMR_COUNT with j1_dout on a TMR_RELOAD write (both registers take the value).
REQ-019 SHALL otherwise each cycle: if TMR_COUNT != 0 decrement; if TMR_COUNT == 0 and TMR_RELOAD != 0, load TMR_RELOAD and set EVT_STATUS[NUM_EVT]; if both zero hold (timer stopped).
REQ-020 SHALL give a timer period of TMR_RELOAD+1 cycles; EVT_RAW[NUM_EVT] reads 1 while TMR_COUNT == 0.
REQ-021 SHALL let a TMR_RELOAD write take priority over decrement/reload in the same cycle.
REQ-022 SHALL read status/enable/raw bits above NUM_EVT as 0.

Reset
REQ-023 SHALL on rst clear gpio_out, gpio_oe, EVT_STATUS, EVT_ENABLE, TMR_RELOAD, TMR_COUNT, sync and edge flops, and irq to 0.
REQ-024 SHALL, for rst asserted mid-count or mid-event, discard the pending event; no status set in the cycle after rst deasserts from pre-reset history.

Configuration
REQ-025 SHALL compile the timer only when macro CSR_EVT_TIMER_EN is defined.
REQ-026 SHALL, without CSR_EVT_TIMER_EN, read offsets 6 and 7 as 16'hBADA, ignore writes to them, and hold status/enable/raw bit NUM_EVT at 0.

Verification
REQ-027 SHALL check: write 16'h00A5 to BASE_ADDR+1 then read -> j1_io_din=16'h00A5, gpio_out=8'hA5; read BASE_ADDR+9 -> 16'hBADA; j1_io_rd low -> 16'hDEAD.
REQ-028 SHALL check: evt_in[2] 0->1 at edge k -> EVT_STATUS=16'h0004 after k+2; with EVT_ENABLE=16'h0004, irq=1 after k+3.
REQ-029 SHALL check: W1C 16'h0004 in same cycle as new evt_in[2] rising edge -> bit stays 1; W1C alone -> status 0, irq 0 one cycle later.
REQ-030 SHALL check (timer on): write TMR_RELOAD=3 -> EVT_STATUS[4] sets every 4 cycles; write 0 -> count reaches 0 and stops, no further sets.
REQ-031 SHALL check: rst pulsed with status, enable, timer, gpio_out nonzero -> all read 0, irq 0 the cycle after.
REQ-032 SHALL check (timer off): read BASE_ADDR+6 -> 16'hBADA; write EVT_ENABLE=16'hFFFF -> reads 16'h000F.
